// File: rtl/ddr_ring_scheduler_if.sv
// Burst request/acknowledge bus between the ring scheduler and the AXI burst engine.
interface ddr_ring_scheduler_if #(
    parameter int unsigned ADDR_WIDTH = 30
);
    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  wr_ack;
    logic                  wr_done;
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_ack;
    logic                  rd_done;

    modport master (
        output wr_req, wr_addr, rd_req, rd_addr,
        input  wr_ack, wr_done, rd_ack, rd_done
    );

    modport slave (
        input  wr_req, wr_addr, rd_req, rd_addr,
        output wr_ack, wr_done, rd_ack, rd_done
    );
endinterface

// File: rtl/ddr_ring_scheduler.sv
// DDR ring-buffer burst scheduler: arbitrates write drains and read refills,
// tracks ring pointers and fill level, and gates reads behind a delay threshold.
module ddr_ring_scheduler #(
    parameter int unsigned ADDR_WIDTH  = 30,
    parameter int unsigned ADDR_BASE   = 0,
    parameter int unsigned BURST_BYTES = 2048,
    parameter int unsigned BURST_WORDS = 64,
    parameter int unsigned RING_BURSTS = 1024,
    parameter int unsigned FIFO_CNT_W  = 12,
    parameter int unsigned WR_URGENT   = 3072
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_work,
    input  logic                          calib_done,
    input  logic [31:0]                   delay_thread,
    input  logic [FIFO_CNT_W-1:0]         wr_fifo_cnt,
    input  logic [FIFO_CNT_W-1:0]         rd_fifo_free,
    ddr_ring_scheduler_if.master          bus,
    output logic [$clog2(RING_BURSTS):0]  fill_level,
    output logic                          rd_enabled,
    output logic                          overflow,
    output logic                          busy
);
    localparam int unsigned PTR_W       = $clog2(RING_BURSTS);
    localparam int unsigned FILL_W      = PTR_W + 1;
    localparam int unsigned BURST_SHIFT = $clog2(BURST_BYTES);

    typedef enum logic [2:0] {IDLE, ARB, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT} state_t;

    state_t           state;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             last_wr;

    logic [31:0] rd_thresh;
    logic        wr_urgent;
    logic        wr_elig;
    logic        rd_elig;
    logic        ring_full;
    logic        pick_wr;

    // Threshold clamped to [1, RING_BURSTS] so reads can always be released.
    assign rd_thresh = (delay_thread == 32'd0) ? 32'd1 :
                       (delay_thread > 32'(RING_BURSTS)) ? 32'(RING_BURSTS) : delay_thread;
    assign wr_urgent = 32'(wr_fifo_cnt) >= 32'(WR_URGENT);
    assign ring_full = 32'(fill_level) == 32'(RING_BURSTS);
    assign wr_elig   = (32'(wr_fifo_cnt) >= 32'(BURST_WORDS)) && !ring_full;
    assign rd_elig   = rd_enabled && (fill_level != '0) &&
                       (32'(rd_fifo_free) >= 32'(BURST_WORDS));
    assign pick_wr   = wr_elig && (!rd_elig || wr_urgent || !last_wr);

    function automatic logic [ADDR_WIDTH-1:0] burst_addr(input logic [PTR_W-1:0] p);
        return ADDR_WIDTH'(ADDR_BASE) + (ADDR_WIDTH'(p) << BURST_SHIFT);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fill_level  <= '0;
            last_wr     <= 1'b0;
            rd_enabled  <= 1'b0;
            overflow    <= 1'b0;
            busy        <= 1'b0;
            bus.wr_req  <= 1'b0;
            bus.rd_req  <= 1'b0;
            bus.wr_addr <= ADDR_WIDTH'(ADDR_BASE);
            bus.rd_addr <= ADDR_WIDTH'(ADDR_BASE);
        end else if (state != IDLE && !calib_done) begin
            // Calibration loss abandons any outstanding burst; overflow history is kept.
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            rd_enabled <= 1'b0;
            busy       <= 1'b0;
            bus.wr_req <= 1'b0;
            bus.rd_req <= 1'b0;
        end else begin
            if (state != IDLE && 32'(fill_level) >= rd_thresh) begin
                rd_enabled <= 1'b1;
            end
            case (state)
                IDLE: begin
                    wr_ptr     <= '0;
                    rd_ptr     <= '0;
                    fill_level <= '0;
                    rd_enabled <= 1'b0;
                    if (start_work && calib_done) begin
                        state <= ARB;
                    end
                end
                ARB: begin
                    if (ring_full && wr_urgent) begin
                        overflow <= 1'b1;
                    end
                    if (!start_work) begin
                        state      <= IDLE;
                        wr_ptr     <= '0;
                        rd_ptr     <= '0;
                        fill_level <= '0;
                        rd_enabled <= 1'b0;
                    end else if (pick_wr) begin
                        state       <= WR_REQ;
                        bus.wr_req  <= 1'b1;
                        bus.wr_addr <= burst_addr(wr_ptr);
                        busy        <= 1'b1;
                        last_wr     <= 1'b1;
                    end else if (rd_elig) begin
                        state       <= RD_REQ;
                        bus.rd_req  <= 1'b1;
                        bus.rd_addr <= burst_addr(rd_ptr);
                        busy        <= 1'b1;
                        last_wr     <= 1'b0;
                    end
                end
                WR_REQ: begin
                    if (bus.wr_ack) begin
                        state      <= WR_WAIT;
                        bus.wr_req <= 1'b0;
                    end
                end
                WR_WAIT: begin
                    if (bus.wr_done) begin
                        state      <= ARB;
                        wr_ptr     <= wr_ptr + PTR_W'(1);
                        fill_level <= fill_level + FILL_W'(1);
                        busy       <= 1'b0;
                    end
                end
                RD_REQ: begin
                    if (bus.rd_ack) begin
                        state      <= RD_WAIT;
                        bus.rd_req <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (bus.rd_done) begin
                        state      <= ARB;
                        rd_ptr     <= rd_ptr + PTR_W'(1);
                        fill_level <= fill_level - FILL_W'(1);
                        busy       <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ddr_ring_scheduler.sv
// Directed bench for ddr_ring_scheduler: vector table for arbitration plus
// hand-written sequences for fill-to-full, wrap, stop, calibration loss and reset.
module tb_ddr_ring_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic        start_work;
    logic        calib_done;
    logic [31:0] delay_thread;
    logic [11:0] wr_fifo_cnt;
    logic [11:0] rd_fifo_free;
    logic [10:0] fill_level;
    logic        rd_enabled;
    logic        overflow;
    logic        busy;

    ddr_ring_scheduler_if #(.ADDR_WIDTH(30)) bus ();

    ddr_ring_scheduler dut (
        .clk(clk), .rst(rst), .start_work(start_work), .calib_done(calib_done),
        .delay_thread(delay_thread), .wr_fifo_cnt(wr_fifo_cnt), .rd_fifo_free(rd_fifo_free),
        .bus(bus), .fill_level(fill_level), .rd_enabled(rd_enabled),
        .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int          wr_cnt;
        int          rd_free;
        int          kind;      // 0 none, 1 write, 2 read
        logic [29:0] addr;
        int          fill;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Waits for a request, then acks it and pulses done on the following cycle.
    task automatic burst(output int kind, output logic [29:0] addr, input int timeout);
        kind = 0;
        addr = '0;
        for (int i = 0; i < timeout && kind == 0; i++) begin
            @(negedge clk);
            if (bus.wr_req) begin
                kind = 1; addr = bus.wr_addr;
            end else if (bus.rd_req) begin
                kind = 2; addr = bus.rd_addr;
            end
        end
        if (kind == 1) begin
            bus.wr_ack = 1'b1;
            @(negedge clk);
            bus.wr_ack = 1'b0; bus.wr_done = 1'b1;
            @(negedge clk);
            bus.wr_done = 1'b0;
        end else if (kind == 2) begin
            bus.rd_ack = 1'b1;
            @(negedge clk);
            bus.rd_ack = 1'b0; bus.rd_done = 1'b1;
            @(negedge clk);
            bus.rd_done = 1'b0;
        end
    endtask

    task automatic wait_req(input logic want_wr, output logic got);
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            got = want_wr ? bus.wr_req : bus.rd_req;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int          kind;
        logic [29:0] addr;
        logic [29:0] prev_w;
        logic [29:0] prev_r;
        logic        got;
        int          wp, rp, errs;
        logic        saw_wr_wrap, saw_rd_wrap;

        tbl[0] = '{100,  64, 2, 30'h0000, 3};
        tbl[1] = '{100,  64, 1, 30'h2000, 4};
        tbl[2] = '{100,  64, 2, 30'h0800, 3};
        tbl[3] = '{100,  64, 1, 30'h2800, 4};
        tbl[4] = '{3072, 64, 1, 30'h3000, 5};
        tbl[5] = '{3072, 64, 1, 30'h3800, 6};
        tbl[6] = '{0,    64, 2, 30'h1000, 5};
        tbl[7] = '{100,   0, 1, 30'h4000, 6};
        tbl[8] = '{0,     0, 0, 30'h0000, 6};

        rst = 1'b1; start_work = 1'b0; calib_done = 1'b0; delay_thread = 32'd0;
        wr_fifo_cnt = '0; rd_fifo_free = '0;
        bus.wr_ack = 1'b0; bus.wr_done = 1'b0; bus.rd_ack = 1'b0; bus.rd_done = 1'b0;
        #12;
        check("rst_wr_req", 64'(bus.wr_req), 64'd0);
        check("rst_rd_req", 64'(bus.rd_req), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_fill", 64'(fill_level), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Startup: four writes before reads are released at fill 4.
        calib_done = 1'b1; start_work = 1'b1; wr_fifo_cnt = 12'd64; rd_fifo_free = 12'd64;
        delay_thread = 32'd4;
        for (int i = 0; i < 4; i++) begin
            burst(kind, addr, 10);
            check($sformatf("start_kind%0d", i), 64'(kind), 64'd1);
            check($sformatf("start_addr%0d", i), 64'(addr), 64'(i * 2048));
            check($sformatf("start_fill%0d", i), 64'(fill_level), 64'(i + 1));
        end
        check("start_rden_early", 64'(rd_enabled), 64'd0);
        wr_fifo_cnt = 12'd0;
        @(negedge clk);
        check("start_rden_rise", 64'(rd_enabled), 64'd1);
        check("start_no_rdreq", 64'(bus.rd_req), 64'd0);

        // Arbitration table: alternation, urgency, single-side and idle cases.
        for (int i = 0; i < 9; i++) begin
            wr_fifo_cnt  = 12'(tbl[i].wr_cnt);
            rd_fifo_free = 12'(tbl[i].rd_free);
            burst(kind, addr, 8);
            check($sformatf("tbl%0d_kind", i), 64'(kind), 64'(tbl[i].kind));
            if (tbl[i].kind != 0) check($sformatf("tbl%0d_addr", i), 64'(addr), 64'(tbl[i].addr));
            check($sformatf("tbl%0d_fill", i), 64'(fill_level), 64'(tbl[i].fill));
        end

        // Fill the ring with urgent writes, then confirm writes stop and overflow sticks.
        wr_fifo_cnt = 12'd3072; rd_fifo_free = 12'd0;
        wp = 9; errs = 0;
        for (int i = 0; i < 1018; i++) begin
            burst(kind, addr, 8);
            if (kind != 1 || addr != 30'(wp * 2048)) errs++;
            if (fill_level > 11'd1024) errs++;
            wp = (wp + 1) % 1024;
        end
        check("full_write_errs", 64'(errs), 64'd0);
        check("full_fill", 64'(fill_level), 64'd1024);
        burst(kind, addr, 10);
        check("full_no_wr", 64'(kind), 64'd0);
        check("full_ovf", 64'(overflow), 64'd1);

        // Wrap-around: read/write pairs crossing pointer 1023 on both sides.
        wr_fifo_cnt = 12'd100; rd_fifo_free = 12'd64;
        rp = 3; wp = 3; errs = 0; saw_wr_wrap = 1'b0; saw_rd_wrap = 1'b0;
        prev_w = '1; prev_r = '1;
        for (int i = 0; i < 1030; i++) begin
            burst(kind, addr, 8);
            if (kind != 2 || addr != 30'(rp * 2048)) errs++;
            if (prev_r == 30'h1FF800 && addr == 30'h0) saw_rd_wrap = 1'b1;
            prev_r = addr; rp = (rp + 1) % 1024;
            burst(kind, addr, 8);
            if (kind != 1 || addr != 30'(wp * 2048)) errs++;
            if (prev_w == 30'h1FF800 && addr == 30'h0) saw_wr_wrap = 1'b1;
            prev_w = addr; wp = (wp + 1) % 1024;
            if (fill_level > 11'd1024) errs++;
        end
        check("wrap_errs", 64'(errs), 64'd0);
        check("wrap_rd_seen", 64'(saw_rd_wrap), 64'd1);
        check("wrap_wr_seen", 64'(saw_wr_wrap), 64'd1);
        check("wrap_ovf_sticky", 64'(overflow), 64'd1);

        // Stop during WR_WAIT: done still counted, then IDLE clears state.
        wr_fifo_cnt = 12'd0; rd_fifo_free = 12'd64;
        burst(kind, addr, 8);
        check("stop_pre_rd", 64'(addr), 64'h4800);
        wr_fifo_cnt = 12'd100; rd_fifo_free = 12'd0;
        wait_req(1'b1, got);
        check("stop_wrreq", 64'(got), 64'd1);
        check("stop_wraddr", 64'(bus.wr_addr), 64'h4800);
        bus.wr_ack = 1'b1;
        @(negedge clk);
        bus.wr_ack = 1'b0; start_work = 1'b0;
        check("stop_req_drop", 64'(bus.wr_req), 64'd0);
        check("stop_busy_wait", 64'(busy), 64'd1);
        @(negedge clk);
        check("stop_busy_hold", 64'(busy), 64'd1);
        bus.wr_done = 1'b1;
        @(negedge clk);
        bus.wr_done = 1'b0;
        check("stop_done_fill", 64'(fill_level), 64'd1024);
        @(negedge clk);
        check("stop_idle_fill", 64'(fill_level), 64'd0);
        check("stop_idle_rden", 64'(rd_enabled), 64'd0);
        check("stop_idle_busy", 64'(busy), 64'd0);
        check("stop_idle_ovf", 64'(overflow), 64'd1);

        // Calibration loss during RD_REQ, with threshold 0 clamped to 1.
        delay_thread = 32'd0; wr_fifo_cnt = 12'd64; rd_fifo_free = 12'd0; start_work = 1'b1;
        burst(kind, addr, 10);
        check("cal_wr_addr", 64'(addr), 64'd0);
        check("cal_fill1", 64'(fill_level), 64'd1);
        wr_fifo_cnt = 12'd0; rd_fifo_free = 12'd64;
        @(negedge clk);
        check("cal_rden_thr1", 64'(rd_enabled), 64'd1);
        wait_req(1'b0, got);
        check("cal_rdreq", 64'(got), 64'd1);
        check("cal_rdaddr", 64'(bus.rd_addr), 64'd0);
        calib_done = 1'b0;
        @(negedge clk);
        check("cal_rdreq_drop", 64'(bus.rd_req), 64'd0);
        check("cal_busy", 64'(busy), 64'd0);
        check("cal_fill0", 64'(fill_level), 64'd0);
        calib_done = 1'b1;
        @(negedge clk);
        bus.rd_ack = 1'b1; bus.rd_done = 1'b1;
        @(negedge clk);
        bus.rd_ack = 1'b0; bus.rd_done = 1'b0;
        @(negedge clk);
        check("cal_late_done_fill", 64'(fill_level), 64'd0);
        check("cal_late_done_req", 64'(bus.rd_req), 64'd0);

        // Asynchronous reset in the middle of WR_REQ.
        wr_fifo_cnt = 12'd64; rd_fifo_free = 12'd0;
        burst(kind, addr, 10);
        check("ar_first_addr", 64'(addr), 64'd0);
        wait_req(1'b1, got);
        check("ar_wrreq", 64'(got), 64'd1);
        check("ar_wraddr", 64'(bus.wr_addr), 64'h800);
        #2 rst = 1'b1;
        #1;
        check("ar_wr_req", 64'(bus.wr_req), 64'd0);
        check("ar_busy", 64'(busy), 64'd0);
        check("ar_fill", 64'(fill_level), 64'd0);
        check("ar_rden", 64'(rd_enabled), 64'd0);
        check("ar_ovf", 64'(overflow), 64'd0);
        check("ar_wr_addr", 64'(bus.wr_addr), 64'd0);
        check("ar_rd_req", 64'(bus.rd_req), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/ddr_ring_scheduler.md
# ddr_ring_scheduler

Burst scheduler that sequences the DDR4 ring buffer behind the FIFO datapath. It decides when a write burst drains the write staging FIFO into DDR and when a read burst refills the read FIFO from DDR. It maintains the ring write/read pointers and the fill level, and holds reads off until the programmed delay threshold is reached. It sits between the staging FIFOs and the AXI burst engine in the MIG clock domain.

## Interface

**Parameters**
- `ADDR_WIDTH`, 30: DDR byte-address width.
- `ADDR_BASE`, 0: ring base byte address. Must be aligned to `BURST_BYTES`.
- `BURST_BYTES`, 2048: bytes per burst. Power of two.
- `BURST_WORDS`, 64: FIFO words moved per burst.
- `RING_BURSTS`, 1024: ring size in bursts. Power of two.
- `FIFO_CNT_W`, 12: width of the FIFO count inputs.
- `WR_URGENT`, 3072: write FIFO count at or above which writes win arbitration.

**Ports**
- `clk` in 1: MIG UI clock.
- `rst` in 1: asynchronous, active-high reset.
- `start_work` in 1: run enable (level).
- `calib_done` in 1: MIG calibration complete.
- `delay_thread` in 32: read start threshold, in bursts.
- `wr_fifo_cnt` in FIFO_CNT_W: words held in the write staging FIFO.
- `rd_fifo_free` in FIFO_CNT_W: free word slots in the read FIFO.
- `wr_req` out 1, `wr_addr` out ADDR_WIDTH: write burst request and its address.
- `wr_ack` in 1, `wr_done` in 1: write request accepted; write burst complete (1-cycle pulse).
- `rd_req` out 1, `rd_addr` out ADDR_WIDTH: read burst request and its address.
- `rd_ack` in 1, `rd_done` in 1: read request accepted; read burst complete (1-cycle pulse).
- `fill_level` out log2(RING_BURSTS)+1: number of bursts resident in the ring.
- `rd_enabled` out 1: reading has been released by the delay threshold.
- `overflow` out 1: sticky; write data arrived urgently while the ring was full.
- `busy` out 1: a burst is outstanding.

## Operation

**States:** IDLE, ARB, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT.

**IDLE**
- Pointers, `fill_level` and `rd_enabled` are held at 0.
- Go to ARB when `start_work` and `calib_done` are both high.

**ARB**
- Write is eligible when `wr_fifo_cnt >= BURST_WORDS` and `fill_level < RING_BURSTS`.
- Read is eligible when `rd_enabled`, `fill_level > 0` and `rd_fifo_free >= BURST_WORDS`.
- Only write eligible: go to WR_REQ. Only read eligible: go to RD_REQ.
- Both eligible:
  - Write wins if `wr_fifo_cnt >= WR_URGENT`.
  - Otherwise the side not served last wins. The last-served bit resets to "read", so write wins the first tie.
- Neither eligible: stay in ARB.
- `start_work` low while in ARB: go to IDLE and clear pointers, `fill_level` and `rd_enabled`.

**Request and wait states**
- WR_REQ: `wr_req` is high and `wr_addr` is stable. When `wr_ack` is sampled high, go to WR_WAIT; `wr_req` is low from the next cycle.
- WR_WAIT: on `wr_done`, increment the write pointer (mod RING_BURSTS), increment `fill_level`, and go to ARB.
- RD_REQ and RD_WAIT behave the same way on the read side. On `rd_done`, increment the read pointer and decrement `fill_level`.
- `start_work` low during a REQ or WAIT state: the current burst completes (ack, then done), then the FSM goes to IDLE via ARB.

**Addressing and fill**
- Address = `ADDR_BASE + ptr*BURST_BYTES`, where `ptr` is log2(RING_BURSTS) bits and wraps from RING_BURSTS-1 to 0.
- Only one burst is ever outstanding, so `fill_level` never sees a simultaneous increment and decrement.

**Read release**
- Effective threshold = `max(1, min(delay_thread, RING_BURSTS))`.
- `rd_enabled` sets on the first cycle `fill_level >= threshold`. It stays set until the FSM returns to IDLE.

**Overflow**
- `overflow` sets in ARB when `fill_level == RING_BURSTS` and `wr_fifo_cnt >= WR_URGENT`.
- It is cleared only by `rst`.

**Protocol errors**
- `*_ack` or `*_done` pulses outside the matching state are ignored.

**Calibration loss**
- `calib_done` low in any non-IDLE state forces IDLE on the next cycle.
- Pointers and `fill_level` are cleared; `overflow` is kept.
- An outstanding burst is abandoned, and its later done pulse is ignored.

## Timing

- **Reset values:** FSM in IDLE; `wr_req`, `rd_req`, `busy`, `fill_level`, `rd_enabled` and `overflow` are 0; `wr_addr` and `rd_addr` are `ADDR_BASE`.
- **Outputs:** all registered; there is no combinational path from input to output.
- **ARB to request:** ARB samples eligibility in cycle N; `*_req` and `*_addr` are valid in cycle N+1.
- **Ack handshake:** ack in the same cycle that req rises is accepted, so the minimum req high time is 1 cycle.
- **Done to next request:** done in cycle M updates pointer and fill in cycle M+1 and returns to ARB; the earliest next `*_req` is M+2.
- **Address update:** `*_addr` changes only on the cycle after the FSM enters the matching REQ state.
- **`busy`:** high in REQ and WAIT states; low in IDLE and ARB.
- **Read release timing:** `rd_enabled` rises in the cycle after `fill_level` reaches the threshold.

## Test plan

1. **Startup.** Reset, `calib_done`=1, `start_work`=1, `wr_fifo_cnt`=64, `delay_thread`=4. Required: 4 writes at addresses 0, 2048, 4096, 6144; no `rd_req` before `fill_level`=4; `rd_enabled` rises 1 cycle later.
2. **Alternation.** Both sides eligible, `wr_fifo_cnt`=100 (below `WR_URGENT`). Required: requests alternate write, read, write, read; `fill_level` stays constant across each pair.
3. **Urgency.** `wr_fifo_cnt`=3072 with a read also eligible. Required: writes granted back-to-back. Then drive the ring full (1024 bursts). Required: no `wr_req`, and `overflow`=1 (sticky).
4. **Wrap-around.** Run 1030 write/read pairs. Required: the address after 0x1FF800 is 0x0 on both sides, and `fill_level` never exceeds 1024.
5. **Stop mid-burst.** Deassert `start_work` during WR_WAIT. Required: `wr_done` is honoured, then IDLE with `fill_level`=0 and `rd_enabled`=0. Separately, drop `calib_done` during RD_REQ. Required: IDLE the next cycle, `rd_req`=0, and a late `rd_done` has no effect.
6. **Async reset.** Assert `rst` mid-WR_REQ, between clock edges. Required: `wr_req`=0 immediately and all outputs at their reset values.
